// File: rtl/byte_stream_reader.sv
// -----------------------------------------------------------------------------
// byte_stream_reader
//
// Consumer side of an 8-bit registered data stream. Each qualified byte is
// written into a small first-word-fall-through FIFO and handed downstream over
// a valid/ready interface. This lets a free-running producer feed a consumer
// that may stall. If the FIFO is full and nothing is popped in the same
// cycle, the incoming byte is dropped and a sticky overflow flag is set.
//
// Handshake: a byte moves downstream on every rising edge where
// out_valid=1 and out_ready=1. out_valid depends only on FIFO state and never
// on out_ready. out_data is held stable while out_valid=1 and out_ready=0.
// The producer side has no backpressure: in_valid=1 always offers a byte,
// and that byte is either stored or dropped.
//
// Parameters
//   ADDR_W     FIFO address width, DEPTH = 2**ADDR_W entries (1..6)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous reset, active-high
//   data_in    byte from the producer register stage
//   in_valid   data_in carries a new byte this cycle
//   out_data   head-of-FIFO byte, 8'h00 while out_valid=0
//   out_valid  FIFO non-empty
//   out_ready  downstream accepts the head byte this cycle
//   level      current occupancy, 0..DEPTH
//   overflow   sticky flag: at least one byte was dropped
//   clr_ovf    synchronous clear of overflow (a new drop in the same cycle wins)
//   byte_count bytes popped since reset, wraps at 16 bits
//              (exists only when BYTE_READER_COUNT_EN is defined)
//
// Optional feature macro: BYTE_READER_COUNT_EN
// -----------------------------------------------------------------------------
module byte_stream_reader #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data_in,
    input  logic              in_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
`ifdef BYTE_READER_COUNT_EN
    input  logic              clr_ovf,
    output logic [15:0]       byte_count
`else
    input  logic              clr_ovf
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;

    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot for the new byte.
    assign push      = in_valid & (~full | pop);
    assign drop      = in_valid & full & ~pop;

    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
    assign level     = count_q;

    // The storage array is not reset. Writes are blocked while rst is high
    // so that no byte is sampled during reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            // Both pointers wrap at DEPTH because they are exactly ADDR_W bits wide.
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            // A drop in this cycle sets the flag even when clr_ovf is high.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef BYTE_READER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count <= 16'h0000;
        end else if (pop) begin
            byte_count <= byte_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_byte_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_byte_stream_reader
//
// Directed bench for byte_stream_reader with ADDR_W=2 (DEPTH=4). A reference
// queue models the FIFO, and a second model tracks the overflow flag and the
// pop count. Every cycle step compares the DUT outputs with this model just
// before the rising edge. Named checks also compare against values worked
// out by hand at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_byte_stream_reader;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        data_in = 8'h00;
    logic              in_valid = 1'b0;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              clr_ovf = 1'b0;
`ifdef BYTE_READER_COUNT_EN
    logic [15:0]       byte_count;
`endif

    always #5 clk = ~clk;

    byte_stream_reader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
`ifdef BYTE_READER_COUNT_EN
        .clr_ovf    (clr_ovf),
        .byte_count (byte_count)
`else
        .clr_ovf    (clr_ovf)
`endif
    );

    // ---------------- scoreboard / model ----------------
    logic [7:0]  exp_q[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_cnt = 16'h0000;
    int          vectors = 0;
    int          miscompares = 0;
    int          stream_pops = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply the inputs, compare the DUT with the model before
    // the edge, advance the model, then move to 1 ns after the rising edge.
    task automatic cycle(input logic [7:0] din, input logic vld, input logic rdy,
                         input logic clr);
        logic mpop;
        logic mfull;
        logic mpush;
        data_in   = din;
        in_valid  = vld;
        out_ready = rdy;
        clr_ovf   = clr;
        chk("out_valid", 16'(out_valid), 16'(exp_q.size() > 0));
        chk("out_data", 16'(out_data), (exp_q.size() > 0) ? 16'(exp_q[0]) : 16'h0000);
        chk("level", 16'(level), 16'(exp_q.size()));
        chk("overflow", 16'(overflow), 16'(m_ovf));
`ifdef BYTE_READER_COUNT_EN
        chk("byte_count", byte_count, m_cnt);
`endif
        mpop  = (exp_q.size() > 0) && rdy;
        mfull = (exp_q.size() == DEPTH);
        mpush = vld && (!mfull || mpop);
        if (mpop) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 16'h0001;
        end
        if (mpush) exp_q.push_back(din);
        if (vld && mfull && !mpop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 16'(level), 16'h0000);
        chk("rst_valid", 16'(out_valid), 16'h0000);
        chk("rst_data", 16'(out_data), 16'h0000);
        chk("rst_ovf", 16'(overflow), 16'h0000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single byte held until out_ready
        cycle(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("single_valid", 16'(out_valid), 16'h0001);
        chk("single_data", 16'(out_data), 16'h00A5);
        chk("single_level", 16'(level), 16'h0001);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        chk("single_hold", 16'(out_data), 16'h00A5);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        chk("single_gone", 16'(out_valid), 16'h0000);

        // Fill 01..04 back to back, then pop in order
        for (int i = 1; i <= 4; i++) cycle(8'(i), 1'b1, 1'b0, 1'b0);
        chk("fill_level", 16'(level), 16'h0004);
        chk("fill_head", 16'(out_data), 16'h0001);
        for (int i = 1; i <= 4; i++) begin
            chk("fill_order", 16'(out_data), 16'(i));
            cycle(8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("fill_empty", 16'(out_valid), 16'h0000);
        chk("fill_empty_data", 16'(out_data), 16'h0000);

        // Overflow: fill with 10..13, offer EE with no pop
        for (int i = 0; i < 4; i++) cycle(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
        cycle(8'hEE, 1'b1, 1'b0, 1'b0);
        chk("ovf_set", 16'(overflow), 16'h0001);
        chk("ovf_level", 16'(level), 16'h0004);
        cycle(8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 16'(overflow), 16'h0000);
        // A drop in the same cycle as clr_ovf leaves the flag set
        cycle(8'hEF, 1'b1, 1'b0, 1'b1);
        chk("ovf_set_wins", 16'(overflow), 16'h0001);
        cycle(8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr2", 16'(overflow), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", 16'(out_data), 16'h0010 + 16'(i));
            cycle(8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("ovf_drained", 16'(out_valid), 16'h0000);

        // Full with push and pop together for 8 cycles
        for (int i = 0; i < 4; i++) cycle(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("fpp_head", 16'(out_data), 16'h0020 + 16'(i));
            cycle(8'h24 + 8'(i), 1'b1, 1'b1, 1'b0);
            chk("fpp_level", 16'(level), 16'h0004);
            chk("fpp_ovf", 16'(overflow), 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            chk("fpp_tail", 16'(out_data), 16'h0028 + 16'(i));
            cycle(8'h00, 1'b0, 1'b1, 1'b0);
        end

        // Stream 300 bytes at one byte per cycle with the consumer always ready
        for (int i = 0; i < 300; i++) begin
            if (out_valid) stream_pops++;
            cycle(8'(i), 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            if (out_valid) stream_pops++;
            cycle(8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("stream_pops", 16'(stream_pops), 16'd300);
        chk("stream_empty", 16'(out_valid), 16'h0000);
`ifdef BYTE_READER_COUNT_EN
        // Popped before the stream: 1 + 4 + 4 + 12 = 21, plus the 300 streamed bytes
        chk("count_total", byte_count, 16'd321);
`endif

        // Reset in the middle of the stream, asserted between edges
        for (int i = 0; i < 3; i++) cycle(8'h30 + 8'(i), 1'b1, 1'b0, 1'b0);
        chk("mid_level_pre", 16'(level), 16'h0003);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_level", 16'(level), 16'h0000);
        chk("mid_valid", 16'(out_valid), 16'h0000);
        chk("mid_data", 16'(out_data), 16'h0000);
`ifdef BYTE_READER_COUNT_EN
        chk("mid_count", byte_count, 16'h0000);
`endif
        exp_q.delete();
        m_ovf = 1'b0;
        m_cnt = 16'h0000;
        #2 rst = 1'b0;
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("post_rst_data", 16'(out_data), 16'h005A);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
